// File: rtl/counter_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_share_arbiter_if
// Purpose  : Request/grant bundle between timing clients and the shared
//            counter arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [CNT_W-1:0]         cnt_value;
    logic [NUM_REQ-1:0]       done;
    logic                     abort_flag;

    modport master (
        output req, req_len,
        input  grant, busy, cnt_value, done, abort_flag
    );

    modport slave (
        input  req, req_len,
        output grant, busy, cnt_value, done, abort_flag
    );
endinterface
`default_nettype wire

// File: rtl/counter_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : counter_share_arbiter
// Purpose  : Round-robin arbiter sharing one up counter among NUM_REQ clients.
//            Define CNT_ARB_FIXED_PRIO_EN for lowest-index fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module counter_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                    clk,
    input  logic                    clear_n,
    counter_share_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_winner;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_abort;
    logic               w_owner_req;

    assign w_owner_req = bus.req[r_owner];

`ifdef CNT_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_winner = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] r_ptr;

    // Scan farthest-first so the candidate nearest to ptr+1 overrides.
    always_comb begin
        w_winner = r_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_winner = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_ptr <= PTR_W'(NUM_REQ - 1);
        end else if ((r_state == c_COUNT && !w_owner_req) || r_state == c_DONE) begin
            r_ptr <= r_owner;
        end
    end
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state  <= c_IDLE;
            r_owner  <= '0;
            r_target <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt   <= '0;
                    r_done  <= '0;
                    r_abort <= 1'b0;
                    if (|bus.req) begin
                        r_state  <= c_COUNT;
                        r_owner  <= w_winner;
                        r_grant  <= c_ONE << w_winner;
                        r_target <= bus.req_len[int'(w_winner)*CNT_W +: CNT_W];
                        r_busy   <= 1'b1;
                    end else begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                c_COUNT: begin
                    if (!w_owner_req) begin
                        r_abort <= 1'b1;
                        r_grant <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (r_cnt == r_target) begin
                        r_done  <= r_grant;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= '0;
                    r_done  <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_abort <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.busy       = r_busy;
    assign bus.cnt_value  = r_cnt;
    assign bus.done       = r_done;
    assign bus.abort_flag = r_abort;

endmodule
`default_nettype wire

// File: doc/counter_share_arbiter.md
Name: counter_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one unsigned up counter (cleared to 0 and incremented by 1 per cycle) between NUM_REQ requesters.
- Each requester asks for a count run of a given length. The block grants the counter to one requester at a time, runs it from 0 up to the requested terminal value, and returns a one-cycle done pulse.
- Sits between timing clients and the single shared counter resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter width; unsigned, wraps modulo 2^CNT_W internally

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level; must be held until done or until the requester chooses to abort
- req_len  input  NUM_REQ*CNT_W  terminal count per requester; slice i = req_len[i*CNT_W +: CNT_W]; sampled only at grant
- grant  output  NUM_REQ  one-hot owner of the counter; all-zero when idle
- busy  output  1  high in COUNT and DONE
- cnt_value  output  CNT_W  current shared counter value
- done  output  NUM_REQ  one-cycle pulse on the owner's bit when its run completes
- abort_flag  output  1  one-cycle pulse when a run is abandoned because the owner dropped req

Behaviour:
- Reset (clear_n low, asynchronous): state=IDLE, grant=0, busy=0, cnt_value=0, done=0, abort_flag=0, rr pointer=NUM_REQ-1 so requester 0 has first priority. All outputs are registered.
- FSM has three states: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is high at a clock edge, select the winner by searching from (ptr+1) mod NUM_REQ upward with wrap.
  - Next cycle: grant=onehot(winner), target latched from the winner's req_len slice, cnt_value=0, state=COUNT.
  - With no requests, remain in IDLE with cnt_value held at 0.
- COUNT, checked each edge in this order:
  - (1) Owner's req low -> abort: abort_flag pulses for 1 cycle, grant=0, cnt_value=0, ptr=owner, state=IDLE. No done pulse.
  - (2) Else if cnt_value==target -> state=DONE, done[owner]=1 for that next cycle, grant held, cnt_value held.
  - (3) Else cnt_value increments by 1.
- DONE (exactly 1 cycle):
  - done[owner] high, grant still high.
  - Next edge: grant=0, done=0, ptr=owner, cnt_value=0, state=IDLE.
  - A new arbitration may start only from IDLE, so there is a minimum 1 idle cycle between runs.
- Latency:
  - req sampled high in IDLE at edge t -> grant at t+1 with cnt_value=0.
  - cnt_value reaches L at t+1+L.
  - done high during cycle t+2+L.
  - Total run = L+3 cycles including IDLE.
- Boundaries:
  - L=0: done during t+2.
  - L=2^CNT_W-1 (15 for CNT_W=4): counter reaches 15 and completes. It never wraps during a run; wrap is impossible by construction.
  - req_len changes while granted are ignored.
  - Non-owner req changes never disturb the current run.
  - Simultaneous requests are resolved by round-robin only.
  - A requester whose req is still high after its done competes again; round-robin gives others priority first.
  - clear_n asserted mid-run: immediate return to reset values. No done or abort_flag pulse is generated.
- Invariants: grant is one-hot or zero; done is a subset of grant; done and abort_flag are never both high.

Optional Feature:
- Macro: CNT_ARB_FIXED_PRIO_EN
- Defined: fixed priority replaces round-robin. The lowest-index requesting bit always wins. The pointer logic is removed; abort and done still behave as above.
- Undefined: round-robin as specified.

Test Plan:
- Reset, then req=4'b0001 with len0=3 -> grant=0001 one cycle after req; cnt_value 0,1,2,3; done=0001 on the next cycle; grant=0 the cycle after.
- req=4'b1111, all len=1, held high -> grant order 0,1,2,3,0. Each run takes 4 cycles; done pulses follow the same order.
- len2=0 and len2=15, requester 2 only -> done in cycle t+2 and t+17 respectively; cnt_value peaks at 0 and 15; no wrap.
- req=0010 with len1=8; drop req1 when cnt_value=4 -> abort_flag pulses once; no done; grant=0; cnt_value=0. The next req=0011 grants requester 0 first (pointer moved to 1, so the search wraps from 2 to 0).
- clear_n low mid-run at cnt_value=5 -> all outputs zero asynchronously. After release with req=1000 held, grant goes to requester 3; no stale done pulse.
- With CNT_ARB_FIXED_PRIO_EN defined, req=4'b1010 held -> requester 1 is granted on every consecutive run and requester 3 is starved.
